// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 1-to-2 stream demultiplexer.
//   WIDTH_DEF     : default payload width
//   CH0 / CH1     : channel encodings as carried on in_sel / lock_ch
//   lock_state_e  : packet-lock FSM states (used only with DEMUX_PKT_LOCK_EN)
// -----------------------------------------------------------------------------
package demux_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

endpackage : demux_pkg

// File: rtl/demux_out_slot.sv
// -----------------------------------------------------------------------------
// demux_out_slot
// One-entry holding slot for one output channel of the demultiplexer.
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : synchronous active-low reset, clears full flag and data
//   load_i   : write data_i into the slot this cycle
//   data_i   : payload to load
//   drain_i  : consumer ready; empties a full slot unless a load coincides
//   full_o   : slot holds a beat (drives the channel valid)
//   data_o   : slot payload (drives the channel data)
// The parent only asserts load_i when the slot is empty or being drained,
// so a load never overwrites an undelivered beat.
// -----------------------------------------------------------------------------
module demux_out_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             drain_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (load_i) begin
      // Covers simultaneous drain + fill: stays full with the new beat.
      full_q <= 1'b1;
      data_q <= data_i;
    end else if (drain_i && full_q) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule : demux_out_slot

// File: rtl/demux1t2_32_stream.sv
// -----------------------------------------------------------------------------
// demux1t2_32_stream
// Registered 1-to-2 valid/ready stream demultiplexer. Each input beat is
// steered by in_sel into the one-entry slot of channel 0 or 1; each channel
// drains independently under its own ready.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_data/in_sel/in_valid    : input beat, destination, valid
//   in_ready                   : input accepted (combinational from the
//                                selected channel's full flag and ready)
//   in_last                    : last beat of packet (DEMUX_PKT_LOCK_EN only)
//   outK_data/outK_valid       : channel K slot contents / full flag
//   outK_ready                 : channel K consumer ready
// Build option:
//   DEMUX_PKT_LOCK_EN : adds in_last and a packet lock so every beat of a
//                       packet follows the channel of its first beat.
// -----------------------------------------------------------------------------
module demux1t2_32_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef DEMUX_PKT_LOCK_EN
  input  logic             in_last,
`endif
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
);

  logic ch_sel;
  logic accept;
  logic load0;
  logic load1;
  logic full0;
  logic full1;

`ifdef DEMUX_PKT_LOCK_EN
  // Lock FSM
  //   state     | meaning
  //   ST_IDLE   | between packets; each beat routed by its own in_sel
  //   ST_LOCKED | inside a packet; beats routed to lock_ch_q, in_sel ignored
  lock_state_e state_q;
  logic        lock_ch_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= CH0;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          // Single-beat packets (in_last on the first beat) never lock.
          if (!in_last) begin
            state_q   <= ST_LOCKED;
            lock_ch_q <= in_sel;
          end
        end
        ST_LOCKED: begin
          if (in_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ch_sel = (state_q == ST_LOCKED) ? lock_ch_q : in_sel;
`else
  assign ch_sel = in_sel;
`endif

  // Ready depends only on the target slot, never on in_data.
  always_comb begin
    in_ready = 1'b0;
    if (ch_sel == CH1) in_ready = !full1 || out1_ready;
    else               in_ready = !full0 || out0_ready;
  end

  assign accept = in_valid && in_ready;
  assign load0  = accept && (ch_sel == CH0);
  assign load1  = accept && (ch_sel == CH1);

  demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load0),
    .data_i  (in_data),
    .drain_i (out0_ready),
    .full_o  (full0),
    .data_o  (out0_data)
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load1),
    .data_i  (in_data),
    .drain_i (out1_ready),
    .full_o  (full1),
    .data_o  (out1_data)
  );

  assign out0_valid = full0;
  assign out1_valid = full1;

endmodule : demux1t2_32_stream

// File: tb/tb_demux1t2_32_stream.sv
module tb_demux1t2_32_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
`ifdef DEMUX_PKT_LOCK_EN
  logic        in_last;
`endif
  logic [31:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;

  int errors = 0;
  int checks = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  always #5 clk = ~clk;

  demux1t2_32_stream #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
`ifdef DEMUX_PKT_LOCK_EN
    .in_last    (in_last),
`endif
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every output handshake is matched against the channel's queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL out0_unexpected: got 0x%08h, expected no beat", out0_data);
        end else check("out0_data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL out1_unexpected: got 0x%08h, expected no beat", out1_data);
        end else check("out1_data", out1_data, q1.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a beat, wait (bounded) for in_ready, then record it on acceptance.
  // Leaves in_valid high; the caller drops it when done.
  task automatic send(input logic sel, input logic [31:0] d, input logic last);
    int budget;
    in_sel = sel; in_data = d; in_valid = 1'b1;
`ifdef DEMUX_PKT_LOCK_EN
    in_last = last;
`endif
    budget = 50;
    @(negedge clk);
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 50 cycles");
      tick();
      return;
    end
    @(posedge clk);
    if (sel) q1.push_back(d); else q0.push_back(d);
    #1;
  endtask

  // Expected destination differs from in_sel in locked mode.
  task automatic send_to(input logic sel, input logic dst, input logic [31:0] d, input logic last);
    in_sel = sel; in_data = d; in_valid = 1'b1;
`ifdef DEMUX_PKT_LOCK_EN
    in_last = last;
`endif
    @(negedge clk);
    check("lock_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    if (dst) q1.push_back(d); else q0.push_back(d);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hFFFF0000;
    out0_ready = 1'b1; out1_ready = 1'b1;
`ifdef DEMUX_PKT_LOCK_EN
    in_last = 1'b0;
`endif
    // Reset held 3 clocks with in_valid asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
      check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
      check("rst_out0_data", out0_data, 32'd0);
      check("rst_out1_data", out1_data, 32'd0);
      in_sel = ~in_sel;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_out0_valid", {31'd0, out0_valid}, 32'd0);
    check("post_rst_out1_valid", {31'd0, out1_valid}, 32'd0);
    check("post_rst_out0_data", out0_data, 32'd0);
    check("post_rst_out1_data", out1_data, 32'd0);
    tick();

    // Basic route: 0x11111111 -> out0, 0x22222222 -> out1 on consecutive cycles.
    send(1'b0, 32'h11111111, 1'b1);
    send(1'b1, 32'h22222222, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    // out0 beat was shown last cycle and consumed; out1 beat shown now.
    check("basic_out0_one_cycle", {31'd0, out0_valid}, 32'd0);
    check("basic_out1_valid", {31'd0, out1_valid}, 32'd1);
    @(negedge clk);
    check("basic_out1_one_cycle", {31'd0, out1_valid}, 32'd0);
    tick();

    // Back-pressure on channel 0.
    out0_ready = 1'b0;
    send(1'b0, 32'hA5A5A5A5, 1'b1);
    in_data = 32'h5A5A5A5A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      check("bp_hold_valid", {31'd0, out0_valid}, 32'd1);
      check("bp_hold_data", out0_data, 32'hA5A5A5A5);
      @(posedge clk); #1;
    end
    out0_ready = 1'b1;
    send(1'b0, 32'h5A5A5A5A, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_second_valid", {31'd0, out0_valid}, 32'd1);
    check("bp_second_data", out0_data, 32'h5A5A5A5A);
    @(negedge clk);
    check("bp_no_dup", {31'd0, out0_valid}, 32'd0);
    tick();

    // Independent channels: slot0 held full while ch1 accepts.
    out0_ready = 1'b0;
    send(1'b0, 32'h01234567, 1'b1);
    in_sel = 1'b1; in_data = 32'hDEADBEEF;
    @(negedge clk);
    check("indep_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    q1.push_back(32'hDEADBEEF);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("indep_out1_valid", {31'd0, out1_valid}, 32'd1);
    check("indep_slot0_valid", {31'd0, out0_valid}, 32'd1);
    check("indep_slot0_data", out0_data, 32'h01234567);
    @(posedge clk); #1;
    out0_ready = 1'b1;
    @(negedge clk);
    check("indep_drain", {31'd0, out0_valid}, 32'd1);
    tick();
    tick();

    // Streaming 16 beats to ch1.
    for (int i = 0; i < 16; i++) begin
      in_sel = 1'b1; in_data = 32'(i); in_valid = 1'b1;
      @(negedge clk);
      check("stream_in_ready", {31'd0, in_ready}, 32'd1);
      if (i > 0) check("stream_out1_data", out1_data, 32'(i - 1));
      @(posedge clk);
      q1.push_back(32'(i));
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_last_valid", {31'd0, out1_valid}, 32'd1);
    @(negedge clk);
    check("stream_end_valid", {31'd0, out1_valid}, 32'd0);
    tick();

`ifdef DEMUX_PKT_LOCK_EN
    // 3-beat packet starting on ch1, later beats carry sel=0 but stay on ch1.
    send_to(1'b1, 1'b1, 32'hC0000001, 1'b0);
    send_to(1'b0, 1'b1, 32'hC0000002, 1'b0);
    send_to(1'b0, 1'b1, 32'hC0000003, 1'b1);
    send_to(1'b0, 1'b0, 32'hC0000004, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();

    // Reset in the middle of a ch1 packet must unlock.
    send_to(1'b1, 1'b1, 32'hC0000005, 1'b0);
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send_to(1'b0, 1'b0, 32'hC0000006, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
`endif

    tick(); tick();
    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_demux1t2_32_stream
